// File: rtl/sysbus_mem_responder.sv
// rtl/sysbus_mem_responder.sv - Sysbus memory-side responder backing a simulation DRAM model
module sysbus_mem_responder #(
    parameter int MEM_WORDS    = 4096,
    parameter int READ_LATENCY = 4,
    parameter int TAG_W        = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reqcyc,
    input  logic [63:0]      req,
    input  logic [TAG_W-1:0] reqtag,
    output logic             reqack,
    output logic             respcyc,
    output logic [63:0]      resp,
    output logic [TAG_W-1:0] resptag,
    input  logic             respack,
    input  logic             load_en,
    input  logic [63:0]      load_addr,
    input  logic [63:0]      load_data
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        RD_WAIT,
        RD_BURST,
        WR_DATA,
        WR_RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AW-4:0]    line_q;
    logic [TAG_W-1:0] tag_q;
    logic [2:0]       beat;
    logic [2:0]       beat_nxt;
    logic [LW-1:0]    lat_cnt;
    logic [63:0]      mem [MEM_WORDS];
    logic             unused_load_bits;

    assign beat_nxt         = beat + 3'd1;
    assign unused_load_bits = ^{load_addr[63:3+AW], load_addr[2:0]};

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (reqcyc) state_nxt = ACK;
            ACK:      state_nxt = tag_q[TAG_W-1] ? RD_WAIT : WR_DATA;
            RD_WAIT:  if (lat_cnt == '0) state_nxt = RD_BURST;
            RD_BURST: if (respack && beat == 3'd7) state_nxt = IDLE;
            WR_DATA:  if (reqcyc && beat == 3'd7) state_nxt = WR_RESP;
            WR_RESP:  if (respack) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // registered outputs, beat/latency counters and latched request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reqack  <= 1'b0;
            respcyc <= 1'b0;
            resp    <= '0;
            resptag <= '0;
            beat    <= '0;
            lat_cnt <= '0;
            line_q  <= '0;
            tag_q   <= '0;
        end else begin
            reqack <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqcyc) begin
                        line_q <= req[6 +: AW-3];
                        tag_q  <= reqtag;
                        reqack <= 1'b1;
                    end
                end
                ACK: begin
                    beat    <= '0;
                    lat_cnt <= LW'(READ_LATENCY - 1);
                end
                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        respcyc <= 1'b1;
                        resp    <= mem[{line_q, 3'd0}];
                        resptag <= tag_q;
                        beat    <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end
                end
                RD_BURST: begin
                    if (respack) begin
                        if (beat == 3'd7) begin
                            respcyc <= 1'b0;
                        end else begin
                            beat <= beat_nxt;
                            resp <= mem[{line_q, beat_nxt}];
                        end
                    end
                end
                WR_DATA: begin
                    if (reqcyc) begin
                        beat <= beat_nxt;
                        if (beat == 3'd7) begin
                            respcyc <= 1'b1;
                            resp    <= '0;
                            resptag <= tag_q;
                        end
                    end
                end
                WR_RESP: begin
                    if (respack) respcyc <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // backing store: backdoor load first so a same-word bus write overrides it
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr[3 +: AW]] <= load_data;
        if (state == WR_DATA && reqcyc) mem[{line_q, beat}] <= req;
    end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb/tb_sysbus_mem_responder.sv - directed self-checking bench for sysbus_mem_responder
module tb_sysbus_mem_responder;

    localparam int MEM_WORDS    = 4096;
    localparam int READ_LATENCY = 4;
    localparam int TAG_W        = 13;

    logic             clk = 1'b0;
    logic             reset;
    logic             reqcyc;
    logic [63:0]      req;
    logic [TAG_W-1:0] reqtag;
    logic             reqack;
    logic             respcyc;
    logic [63:0]      resp;
    logic [TAG_W-1:0] resptag;
    logic             respack;
    logic             load_en;
    logic [63:0]      load_addr;
    logic [63:0]      load_data;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_line [8];

    sysbus_mem_responder #(
        .MEM_WORDS   (MEM_WORDS),
        .READ_LATENCY(READ_LATENCY),
        .TAG_W       (TAG_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .reqcyc   (reqcyc),
        .req      (req),
        .reqtag   (reqtag),
        .reqack   (reqack),
        .respcyc  (respcyc),
        .resp     (resp),
        .resptag  (resptag),
        .respack  (respack),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // called at a negedge with the DUT idle; returns at the negedge showing reqack
    task automatic issue(input logic [63:0] a, input logic [TAG_W-1:0] t);
        reqcyc = 1'b1; req = a; reqtag = t;
        @(negedge clk);
        check("reqack", reqack, 1);
        reqcyc = 1'b0; req = '0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!respcyc && n < 50);
    endtask

    // stall=1 drives respack 1,0,0,1,0,0,...
    task automatic read_line(input logic [63:0] a, input logic [TAG_W-1:0] t, input bit stall);
        int n;
        int b;
        int cyc;
        issue(a, t);
        wait_resp(n);
        check("rd_latency", n, READ_LATENCY + 1);
        b = 0;
        cyc = 0;
        while (b < 8 && cyc < 100) begin
            check("rd_respcyc", respcyc, 1);
            check($sformatf("rd_beat%0d", b), resp, exp_line[b]);
            check("rd_tag", resptag, t);
            respack = stall ? (cyc % 3 == 0) : 1'b1;
            @(negedge clk);
            if (respack) b++;
            cyc++;
        end
        respack = 1'b0;
        check("rd_beats", b, 8);
        check("rd_end_respcyc", respcyc, 0);
    endtask

    initial begin
        int n;
        int acks;
        int beats;
        int last_beat;
        reset = 1'b1; reqcyc = 1'b0; req = '0; reqtag = '0; respack = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        #1;
        check("rst_respcyc", respcyc, 0);
        check("rst_reqack", reqack, 0);
        check("rst_resp", resp, 0);
        check("rst_resptag", resptag, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: preload line 0x40 and read with respack held high
        for (int i = 0; i < 8; i++) begin
            exp_line[i] = 64'h1111 * (i + 1);
            preload(64'h40 + 64'(i * 8), exp_line[i]);
        end
        @(negedge clk);
        read_line(64'h40, 13'h1005, 1'b0);
        @(negedge clk);

        // 2: same read with a stalling initiator
        read_line(64'h40, 13'h1005, 1'b1);
        @(negedge clk);

        // 3: write line 0x1000 with bubbles, then read it back
        issue(64'h1000, 13'h0007);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            reqcyc = 1'b1; req = 64'hA0 + 64'(i);
            @(negedge clk);
            if (i % 2 == 1) begin
                reqcyc = 1'b0; req = '0;
                @(negedge clk);
            end
        end
        reqcyc = 1'b0; req = '0;
        if (!respcyc) wait_resp(n);
        check("wr_respcyc", respcyc, 1);
        check("wr_resp", resp, 0);
        check("wr_tag", resptag, 13'h0007);
        @(negedge clk);
        check("wr_hold", respcyc, 1);
        respack = 1'b1;
        @(negedge clk);
        respack = 1'b0;
        check("wr_done", respcyc, 0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) exp_line[i] = 64'hA0 + 64'(i);
        read_line(64'h1000, 13'h1009, 1'b0);
        @(negedge clk);

        // 4: low address bits ignored; address wraps modulo the array
        for (int i = 0; i < 8; i++) exp_line[i] = 64'h1111 * (i + 1);
        read_line(64'h47, 13'h1005, 1'b0);
        @(negedge clk);
        read_line(64'h40 + 64'(MEM_WORDS * 8), 13'h1105, 1'b0);
        @(negedge clk);

        // 5: async reset while beat 3 is presented
        issue(64'h40, 13'h1005);
        wait_resp(n);
        respack = 1'b1;
        repeat (3) @(negedge clk);
        respack = 1'b0;
        check("pre_rst_beat3", resp, exp_line[3]);
        reset = 1'b1;
        #1;
        check("mid_rst_respcyc", respcyc, 0);
        check("mid_rst_reqack", reqack, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        read_line(64'h40, 13'h1005, 1'b0);
        @(negedge clk);

        // 6: reqcyc held high, back-to-back reads
        acks = 0; beats = 0; last_beat = -10;
        reqcyc = 1'b1; req = 64'h40; reqtag = 13'h1005; respack = 1'b1;
        for (int i = 1; i <= 42; i++) begin
            @(negedge clk);
            if (reqack) begin
                acks++;
                if (acks > 1) check("b2b_idle_gap", (i - last_beat) >= 2, 1);
                check("b2b_ack_no_resp", respcyc, 0);
            end
            if (respcyc) begin
                check("b2b_data", resp, exp_line[beats % 8]);
                beats++;
                last_beat = i;
            end
            if (i == 42) reqcyc = 1'b0;
        end
        respack = 1'b0;
        check("b2b_acks", acks, 3);
        check("b2b_beats", beats, 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
